// File: rtl/qlearn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qlearn_pkg
//  Description : Shared Q-learning types and defaults: table geometry, the
//                max-Q search FSM state encoding and the q-table address pack.
//  Revision    : 1.0 - initial release
// ============================================================================
package qlearn_pkg;

    localparam int STATE_WIDTH  = 6;
    localparam int ACTION_WIDTH = 2;
    localparam int NUM_ACTIONS  = 2 ** ACTION_WIDTH;
    localparam int ADDR_WIDTH   = 9;
    localparam int DATA_WIDTH   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } qmax_state_t;

    // Table word for (state, action) lives at {state, action}; callers
    // truncate the result to their own address width.
    function automatic logic [31:0] pack_addr(
        input logic [31:0] state,
        input logic [31:0] action,
        input int          action_width
    );
        return (state << action_width) | action;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_gt.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_gt
//  Description : Combinational IEEE-754 single-precision "a > b" using a
//                sign/magnitude ordering. +0 and -0 compare equal. NaNs are
//                ordered by their raw bits (deterministic, not meaningful).
//  Revision    : 1.0 - initial release
// ============================================================================
module fp32_gt (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        a_gt_b
);

    logic        w_a_neg;
    logic        w_b_neg;
    logic [30:0] w_a_mag;
    logic [30:0] w_b_mag;
    logic        w_both_zero;

    assign w_a_neg     = a[31];
    assign w_b_neg     = b[31];
    assign w_a_mag     = a[30:0];
    assign w_b_mag     = b[30:0];
    assign w_both_zero = (w_a_mag == 31'd0) && (w_b_mag == 31'd0);

    // Sign decides first; equal signs order by magnitude, reversed for negatives.
    always_comb begin
        a_gt_b = 1'b0;
        if (w_both_zero) begin
            a_gt_b = 1'b0;
        end else if (w_a_neg != w_b_neg) begin
            a_gt_b = w_b_neg;
        end else if (!w_a_neg) begin
            a_gt_b = (w_a_mag > w_b_mag);
        end else begin
            a_gt_b = (w_a_mag < w_b_mag);
        end
    end

endmodule
`default_nettype wire

// File: rtl/qmax_select.sv
`default_nettype none
// ============================================================================
//  Module      : qmax_select
//  Description : Reads every action's Q value of one state from the q-table
//                and reports the largest one and its action (lowest index on
//                ties). Optional epsilon-greedy exploration is compiled in
//                with the macro QMAX_EXPLORE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module qmax_select
    import qlearn_pkg::*;
#(
    parameter int STATE_WIDTH  = qlearn_pkg::STATE_WIDTH,
    parameter int ACTION_WIDTH = qlearn_pkg::ACTION_WIDTH,
    parameter int ADDR_WIDTH   = qlearn_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH   = qlearn_pkg::DATA_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [STATE_WIDTH-1:0]  i_state,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [DATA_WIDTH-1:0]   o_max_q,
    output logic [ACTION_WIDTH-1:0] o_max_action,
    output logic [ADDR_WIDTH-1:0]   o_addr_r,
    output logic                    o_read_en,
`ifdef QMAX_EXPLORE_EN
    input  logic [7:0]              i_epsilon,
`endif
    input  logic [DATA_WIDTH-1:0]   i_q_data
);

    localparam int                    c_NUM_ACTIONS = 2 ** ACTION_WIDTH;
    localparam logic [ACTION_WIDTH-1:0] c_LAST_ACT  = ACTION_WIDTH'(c_NUM_ACTIONS - 1);

    qmax_state_t             r_state;
    qmax_state_t             w_state_nxt;
    logic                    w_accept;
    logic [STATE_WIDTH-1:0]  r_sidx;
    logic [ACTION_WIDTH-1:0] r_act;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   w_addr_first;
    logic [ADDR_WIDTH-1:0]   w_addr_next;
    logic                    r_cap_vld;
    logic [ACTION_WIDTH-1:0] r_cap_act;
    logic [DATA_WIDTH-1:0]   r_run_q;
    logic [ACTION_WIDTH-1:0] r_run_act;
    logic [DATA_WIDTH-1:0]   w_run_q_nxt;
    logic [ACTION_WIDTH-1:0] w_run_act_nxt;
    logic                    w_gt;
    logic [DATA_WIDTH-1:0]   w_sel_q;
    logic [ACTION_WIDTH-1:0] w_sel_act;
    logic [DATA_WIDTH-1:0]   r_max_q;
    logic [ACTION_WIDTH-1:0] r_max_act;

    assign w_addr_first = ADDR_WIDTH'(pack_addr(32'(i_state), 32'd0, ACTION_WIDTH));
    assign w_addr_next  = ADDR_WIDTH'(pack_addr(32'(r_sidx), 32'(r_act + 1'b1), ACTION_WIDTH));

    // FSM state register; reset takes priority over a coincident start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        o_read_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                o_read_en = 1'b1;
                if (r_act == c_LAST_ACT) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: w_state_nxt = ST_DONE;
            ST_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read sequencing: latch the state, walk actions 0..N-1, keep the last address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sidx    <= '0;
            r_act     <= '0;
            r_addr    <= '0;
            r_cap_vld <= 1'b0;
            r_cap_act <= '0;
        end else begin
            r_cap_vld <= o_read_en;
            r_cap_act <= r_act;
            if (w_accept) begin
                r_sidx <= i_state;
                r_act  <= '0;
                r_addr <= w_addr_first;
            end else if (o_read_en) begin
                r_act <= r_act + 1'b1;
                if (r_act != c_LAST_ACT) begin
                    r_addr <= w_addr_next;
                end
            end
        end
    end

    assign o_addr_r = r_addr;

    fp32_gt u_gt (
        .a      (i_q_data),
        .b      (r_run_q),
        .a_gt_b (w_gt)
    );

    // Running max including the word arriving this cycle; action 0 seeds it.
    always_comb begin
        w_run_q_nxt   = r_run_q;
        w_run_act_nxt = r_run_act;
        if (r_cap_vld && ((r_cap_act == '0) || w_gt)) begin
            w_run_q_nxt   = i_q_data;
            w_run_act_nxt = r_cap_act;
        end
    end

    // Running-max register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_run_q   <= '0;
            r_run_act <= '0;
        end else begin
            r_run_q   <= w_run_q_nxt;
            r_run_act <= w_run_act_nxt;
        end
    end

`ifdef QMAX_EXPLORE_EN
    logic [7:0]              r_lfsr;
    logic [DATA_WIDTH-1:0]   r_qbuf [c_NUM_ACTIONS];
    logic                    w_explore;
    logic [ACTION_WIDTH-1:0] w_rand_act;
    logic [DATA_WIDTH-1:0]   w_rand_q;

    // Free-running Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= 8'h01;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    // Keep every returned word so a random action can report its own Q value.
    always_ff @(posedge i_clk) begin
        if (r_cap_vld) begin
            r_qbuf[r_cap_act] <= i_q_data;
        end
    end

    assign w_explore  = (r_lfsr < i_epsilon);
    assign w_rand_act = r_lfsr[ACTION_WIDTH-1:0];
    // The last word is still on the bus during DRAIN, not yet in the buffer.
    assign w_rand_q   = (r_cap_vld && (r_cap_act == w_rand_act)) ? i_q_data : r_qbuf[w_rand_act];

    // Exploration overrides the greedy choice when the LFSR falls below epsilon.
    always_comb begin
        w_sel_q   = w_run_q_nxt;
        w_sel_act = w_run_act_nxt;
        if (w_explore) begin
            w_sel_q   = w_rand_q;
            w_sel_act = w_rand_act;
        end
    end
`else
    assign w_sel_q   = w_run_q_nxt;
    assign w_sel_act = w_run_act_nxt;
`endif

    // Result registers change only on the DRAIN->DONE edge and hold otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_max_q   <= '0;
            r_max_act <= '0;
        end else if (r_state == ST_DRAIN) begin
            r_max_q   <= w_sel_q;
            r_max_act <= w_sel_act;
        end
    end

    assign o_max_q      = r_max_q;
    assign o_max_action = r_max_act;

endmodule
`default_nettype wire
